addr_gen_unit: RTL

ADDR_GEN_UNIT -- requirements
Module: addr_gen_unit

---
 rtl/addr_gen_unit_if.sv | 28 ++
 rtl/addr_gen_unit.sv | 79 +++++++
 2 files changed

// File: rtl/addr_gen_unit_if.sv
// addr_gen_unit_if: request and beat-issue bus of the address generation unit
interface addr_gen_unit_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic [15:0]      IR;
    logic [WIDTH-1:0] SR1;
    logic [WIDTH-1:0] PC;
    logic             ADDR1MUX;
    logic [1:0]       ADDR2MUX;
    logic [CNT_W-1:0] BURST_LEN;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ADDR_OUT;
    logic             out_valid;
    logic             out_ready;
    logic             LAST;

    modport master (
        output IR, SR1, PC, ADDR1MUX, ADDR2MUX, BURST_LEN, in_valid, out_ready,
        input  in_ready, ADDR_OUT, out_valid, LAST
    );

    modport slave (
        input  IR, SR1, PC, ADDR1MUX, ADDR2MUX, BURST_LEN, in_valid, out_ready,
        output in_ready, ADDR_OUT, out_valid, LAST
    );
endinterface

// File: rtl/addr_gen_unit.sv
// addr_gen_unit: base+offset address generator issuing strided bursts over a valid/ready handshake
module addr_gen_unit #(
    parameter int          WIDTH  = 16,
    parameter int          CNT_W  = 4,
    parameter int unsigned STRIDE = 1
) (
    input  logic           Clk,
    input  logic           Reset_n,
    addr_gen_unit_if.slave bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] base, offset, start;
    logic [CNT_W-1:0] len_m1;
    logic             beat_acc, last_acc, req_acc;
    logic             unused_ir;

    assign unused_ir = ^bus.IR[15:11];

    // Start address: selected base plus sign-extended IR offset; zero length counts as one beat
    always_comb begin
        base   = bus.ADDR1MUX ? bus.SR1 : bus.PC;
        offset = bus.ADDR2MUX == 2'b00 ? '0 :
                 bus.ADDR2MUX == 2'b01 ? {{(WIDTH-6){bus.IR[5]}}, bus.IR[5:0]} :
                 bus.ADDR2MUX == 2'b10 ? {{(WIDTH-9){bus.IR[8]}}, bus.IR[8:0]} :
                                         {{(WIDTH-11){bus.IR[10]}}, bus.IR[10:0]};
        start  = base + offset;
        len_m1 = bus.BURST_LEN == '0 ? '0 : bus.BURST_LEN - 1'b1;
    end

    // A new request is only taken when idle or in the same cycle the final beat leaves
    assign beat_acc      = (state_q == ISSUE) && bus.out_ready;
    assign last_acc      = beat_acc && last_q;
    assign bus.in_ready  = (state_q == IDLE) || last_acc;
    assign req_acc       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == ISSUE);
    assign bus.ADDR_OUT  = addr_q;
    assign bus.LAST      = last_q;

    // Next state: restart wins over the last-beat drain so back-to-back bursts have no bubble
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (req_acc) begin
            state_d = ISSUE;
            addr_d  = start;
            cnt_d   = len_m1;
            last_d  = (len_m1 == '0);
        end else if (last_acc) begin
            state_d = IDLE;
            last_d  = 1'b0;
        end else if (beat_acc) begin
            addr_d  = addr_q + WIDTH'(STRIDE);
            cnt_d   = cnt_q - 1'b1;
            last_d  = (cnt_q == CNT_W'(1));
        end
    end

    // Burst state and registered outputs, cleared asynchronously by reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end
endmodule
